// File: rtl/mdu_pkg.sv
// Shared encodings for the multiply/divide scheduler: MD operation codes and FSM states.
package mdu_pkg;

  typedef enum logic [1:0] {
    MD_MULT = 2'b00,
    MD_DIV  = 2'b01,
    MD_MADD = 2'b10,
    MD_MSUB = 2'b11
  } md_op_e;

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_MUL  = 2'b01,
    S_DIV  = 2'b10
  } md_state_e;

endpackage

// File: rtl/mdu_arith.sv
// Combinational 32x32 multiply and divide datapath, signed or unsigned.
// Divide by zero gives quot=all-ones, rem=dividend; signed overflow wraps naturally.
module mdu_arith
  import mdu_pkg::*;
(
  input  logic [31:0] i_a,
  input  logic [31:0] i_b,
  input  logic        i_sign,
  output logic [63:0] o_prod,
  output logic [31:0] o_quot,
  output logic [31:0] o_rem
);

  logic        w_a_neg, w_b_neg;
  logic [63:0] w_a_ext, w_b_ext;
  logic [31:0] w_a_mag, w_b_mag;
  logic [31:0] w_q_mag, w_r_mag;

  assign w_a_neg = i_sign & i_a[31];
  assign w_b_neg = i_sign & i_b[31];

  // Sign/zero extension to 64 bits makes a single truncated multiply correct for both modes.
  assign w_a_ext = {{32{w_a_neg}}, i_a};
  assign w_b_ext = {{32{w_b_neg}}, i_b};
  assign o_prod  = w_a_ext * w_b_ext;

  assign w_a_mag = w_a_neg ? (32'd0 - i_a) : i_a;
  assign w_b_mag = w_b_neg ? (32'd0 - i_b) : i_b;
  assign w_q_mag = w_a_mag / w_b_mag;
  assign w_r_mag = w_a_mag % w_b_mag;

  // 0x80000000 / -1: magnitude quotient 0x80000000 negates to itself, remainder 0.
  always_comb begin
    if (i_b == 32'd0) begin
      o_quot = 32'hFFFF_FFFF;
      o_rem  = i_a;
    end else begin
      o_quot = (w_a_neg ^ w_b_neg) ? (32'd0 - w_q_mag) : w_q_mag;
      o_rem  = w_a_neg ? (32'd0 - w_r_mag) : w_r_mag;
    end
  end

endmodule

// File: rtl/mdu_sched.sv
// E-stage multiply/divide scheduler: fixed-latency sequencing, HI/LO ownership,
// MT/MF handling and the md_stall hold towards E_allowin.
module mdu_sched
  import mdu_pkg::*;
#(
  parameter int MUL_LAT = 5,
  parameter int DIV_LAT = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        respon,
  input  logic        E_valid,
  input  logic        startE,
  input  logic [1:0]  MDopE,
  input  logic        MDsignE,
  input  logic        HIWriteE,
  input  logic        HLToRegE,
  input  logic        HIReadE,
  input  logic [31:0] rd1E,
  input  logic [31:0] rd2E,
  output logic        busy,
  output logic        md_stall,
  output logic [31:0] hl_rdata,
  output logic [31:0] HI,
  output logic [31:0] LO
);

  localparam logic [4:0] MUL_CNT0 = 5'(MUL_LAT - 1);
  localparam logic [4:0] DIV_CNT0 = 5'(DIV_LAT - 1);

  md_state_e   r_state, w_state_nxt;
  logic [4:0]  r_cnt, w_cnt_nxt;
  md_op_e      r_op;
  logic        r_sign;
  logic [31:0] r_a, r_b, r_hi, r_lo;

  logic        w_busy, w_go, w_mt, w_done;
  logic [63:0] w_prod, w_hilo_nxt;
  logic [31:0] w_quot, w_rem;

  assign w_busy = (r_state != S_IDLE);
  assign w_go   = E_valid & startE & ~respon & ~w_busy;
  // startE wins over HIWriteE on an illegal combined decode.
  assign w_mt   = E_valid & HIWriteE & ~startE & ~respon & ~w_busy;

  assign busy     = w_busy;
  assign md_stall = E_valid & (startE | HIWriteE | HLToRegE) & w_busy;
  assign hl_rdata = HIReadE ? r_hi : r_lo;
  assign HI       = r_hi;
  assign LO       = r_lo;

  mdu_arith u_arith (
    .i_a    (r_a),
    .i_b    (r_b),
    .i_sign (r_sign),
    .o_prod (w_prod),
    .o_quot (w_quot),
    .o_rem  (w_rem)
  );

  // NOTE: every always_comb output gets a default first, so no path can infer a latch.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_done      = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_go) begin
          if (MDopE == MD_DIV) begin
            w_state_nxt = S_DIV;
            w_cnt_nxt   = DIV_CNT0;
          end else begin
            w_state_nxt = S_MUL;
            w_cnt_nxt   = MUL_CNT0;
          end
        end
      end
      S_MUL, S_DIV: begin
        if (r_cnt == 5'd0) begin
          w_done      = 1'b1;
          w_state_nxt = S_IDLE;
        end else begin
          w_cnt_nxt = r_cnt - 5'd1;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // MADD/MSUB accumulate onto HI/LO as they stand at completion; nothing else can write them while busy.
  always_comb begin
    w_hilo_nxt = {r_hi, r_lo};
    case (r_op)
      MD_MULT: w_hilo_nxt = w_prod;
      MD_MADD: w_hilo_nxt = {r_hi, r_lo} + w_prod;
      MD_MSUB: w_hilo_nxt = {r_hi, r_lo} - w_prod;
      MD_DIV:  w_hilo_nxt = {w_rem, w_quot};
      default: w_hilo_nxt = {r_hi, r_lo};
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_cnt   <= 5'd0;
      r_hi    <= 32'd0;
      r_lo    <= 32'd0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      if (w_done) begin
        {r_hi, r_lo} <= w_hilo_nxt;
      end else if (w_mt) begin
        if (HIReadE) r_hi <= rd1E;
        else         r_lo <= rd1E;
      end
    end
  end

  // NOTE: operand latches carry no reset; they are always loaded by go before the FSM reads them.
  always_ff @(posedge clk) begin
    if (w_go) begin
      r_a    <= rd1E;
      r_b    <= rd2E;
      r_op   <= md_op_e'(MDopE);
      r_sign <= MDsignE;
    end
  end

endmodule

// File: tb/tb_mdu_sched.sv
// Self-checking bench for mdu_sched: directed scenarios plus randomized operations
// compared against a plain-arithmetic HI/LO reference model.
module tb_mdu_sched;

  localparam int MUL_LAT = 5;
  localparam int DIV_LAT = 10;

  logic        clk = 1'b0;
  logic        reset, respon, E_valid, startE, MDsignE, HIWriteE, HLToRegE, HIReadE;
  logic [1:0]  MDopE;
  logic [31:0] rd1E, rd2E;
  logic        busy, md_stall;
  logic [31:0] hl_rdata, HI, LO;

  int n_tests = 0;
  int n_fail  = 0;

  logic [31:0] m_hi = 32'd0;
  logic [31:0] m_lo = 32'd0;

  always #5 clk = ~clk;

  mdu_sched #(.MUL_LAT(MUL_LAT), .DIV_LAT(DIV_LAT)) dut (
    .clk      (clk),
    .reset    (reset),
    .respon   (respon),
    .E_valid  (E_valid),
    .startE   (startE),
    .MDopE    (MDopE),
    .MDsignE  (MDsignE),
    .HIWriteE (HIWriteE),
    .HLToRegE (HLToRegE),
    .HIReadE  (HIReadE),
    .rd1E     (rd1E),
    .rd2E     (rd2E),
    .busy     (busy),
    .md_stall (md_stall),
    .hl_rdata (hl_rdata),
    .HI       (HI),
    .LO       (LO)
  );

  // Reference: {HI,LO} after an operation, straight from the arithmetic definitions.
  function automatic logic [63:0] ref_result(input logic [1:0] op, input logic sg,
                                             input logic [31:0] a, input logic [31:0] b,
                                             input logic [63:0] hilo);
    longint          sa, sb, q, r;
    longint unsigned p;
    logic [63:0]     res;
    sa = sg ? longint'($signed(a)) : longint'({32'd0, a});
    sb = sg ? longint'($signed(b)) : longint'({32'd0, b});
    p  = longint'(sa * sb);
    case (op)
      2'b00: res = p;
      2'b10: res = hilo + p;
      2'b11: res = hilo - p;
      default: begin
        if (b == 32'd0) begin
          res = {a, 32'hFFFF_FFFF};
        end else begin
          q = sa / sb;
          r = sa % sb;
          res = {r[31:0], q[31:0]};
        end
      end
    endcase
    return res;
  endfunction

  task automatic idle_inputs();
    respon = 0; E_valid = 0; startE = 0; MDopE = 2'b00; MDsignE = 0;
    HIWriteE = 0; HLToRegE = 0; HIReadE = 0; rd1E = 0; rd2E = 0;
  endtask

  // mode 0: plain; 1: respon+startE during flight; 2: E_valid=0 with requests during flight.
  task automatic run_op(input logic [1:0] op, input logic sg, input logic [31:0] a,
                        input logic [31:0] b, input int mode, input bit also_mt,
                        input string name);
    logic [63:0] exp;
    int          lat, n;
    lat = (op == 2'b01) ? DIV_LAT : MUL_LAT;
    exp = ref_result(op, sg, a, b, {m_hi, m_lo});
    @(negedge clk);
    E_valid = 1; startE = 1; MDopE = op; MDsignE = sg; rd1E = a; rd2E = b;
    HIWriteE = also_mt; HIReadE = 1'b1;
    @(negedge clk);
    idle_inputs();
    n = 0;
    while (busy === 1'b1 && n < 64) begin
      if (n == 0 && mode == 1) begin
        E_valid = 1; startE = 1; respon = 1; rd1E = 32'h1234_5678;
        #1;
        n_tests++;
        if (md_stall !== 1'b1) begin
          n_fail++; $display("FAIL %s stall_with_respon: got %b want 1", name, md_stall);
        end
      end
      if (n == 0 && mode == 2) begin
        E_valid = 0; startE = 1; HLToRegE = 1;
        #1;
        n_tests++;
        if (md_stall !== 1'b0) begin
          n_fail++; $display("FAIL %s stall_evalid0: got %b want 0", name, md_stall);
        end
      end
      n++;
      @(negedge clk);
      idle_inputs();
    end
    n_tests++;
    if (n !== lat) begin
      n_fail++; $display("FAIL %s busy_cycles: got %0d want %0d", name, n, lat);
    end
    n_tests++;
    if (HI !== exp[63:32] || LO !== exp[31:0]) begin
      n_fail++;
      $display("FAIL %s hilo: got %h_%h want %h_%h", name, HI, LO, exp[63:32], exp[31:0]);
    end
    {m_hi, m_lo} = exp;
  endtask

  task automatic do_mt(input logic hi_sel, input logic [31:0] v, input string name);
    @(negedge clk);
    E_valid = 1; HIWriteE = 1; HIReadE = hi_sel; rd1E = v;
    @(negedge clk);
    idle_inputs();
    if (hi_sel) m_hi = v; else m_lo = v;
    n_tests++;
    if (HI !== m_hi || LO !== m_lo) begin
      n_fail++; $display("FAIL %s: got %h_%h want %h_%h", name, HI, LO, m_hi, m_lo);
    end
  endtask

  task automatic test_reset();
    idle_inputs();
    reset = 1;
    repeat (3) @(negedge clk);
    reset = 0;
    n_tests++;
    if (busy !== 1'b0 || md_stall !== 1'b0 || HI !== 32'd0 || LO !== 32'd0) begin
      n_fail++;
      $display("FAIL reset_state: got busy=%b stall=%b HI=%h LO=%h want 0 0 0 0",
               busy, md_stall, HI, LO);
    end
  endtask

  task automatic test_mult();
    run_op(2'b00, 1'b1, 32'hFFFF_FFFE, 32'd3, 0, 0, "mult_signed");
    n_tests++;
    if (HI !== 32'hFFFF_FFFF || LO !== 32'hFFFF_FFFA) begin
      n_fail++; $display("FAIL mult_signed_const: got %h_%h want ffffffff_fffffffa", HI, LO);
    end
    run_op(2'b00, 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, 0, "mult_unsigned_max");
  endtask

  task automatic test_div_stall();
    int n;
    @(negedge clk);
    E_valid = 1; startE = 1; MDopE = 2'b01; MDsignE = 0; rd1E = 32'd100; rd2E = 32'd7;
    @(negedge clk);
    idle_inputs();
    E_valid = 1; HLToRegE = 1; HIReadE = 0;
    n = 0;
    #1;
    while (md_stall === 1'b1 && n < 64) begin
      n++;
      @(negedge clk);
      #1;
    end
    n_tests++;
    if (n !== DIV_LAT) begin
      n_fail++; $display("FAIL div_stall_cycles: got %0d want %0d", n, DIV_LAT);
    end
    n_tests++;
    if (hl_rdata !== 32'd14) begin
      n_fail++; $display("FAIL mflo_after_div: got %0d want 14", hl_rdata);
    end
    HIReadE = 1;
    #1;
    n_tests++;
    if (hl_rdata !== 32'd2) begin
      n_fail++; $display("FAIL mfhi_after_div: got %0d want 2", hl_rdata);
    end
    @(negedge clk);
    idle_inputs();
    m_hi = 32'd2; m_lo = 32'd14;
  endtask

  task automatic test_div_special();
    run_op(2'b01, 1'b1, 32'hFFFF_FFF9, 32'd2, 0, 0, "div_signed_neg");
    n_tests++;
    if (HI !== 32'hFFFF_FFFF || LO !== 32'hFFFF_FFFD) begin
      n_fail++; $display("FAIL div_m7_2_const: got %h_%h want ffffffff_fffffffd", HI, LO);
    end
    run_op(2'b01, 1'b0, 32'd5, 32'd0, 0, 0, "div_by_zero_u");
    run_op(2'b01, 1'b1, 32'hFFFF_FFF0, 32'd0, 0, 0, "div_by_zero_s");
    run_op(2'b01, 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 0, 0, "div_overflow");
    n_tests++;
    if (HI !== 32'd0 || LO !== 32'h8000_0000) begin
      n_fail++; $display("FAIL div_overflow_const: got %h_%h want 00000000_80000000", HI, LO);
    end
  endtask

  task automatic test_madd_msub();
    do_mt(1'b1, 32'd0, "mthi_0");
    do_mt(1'b0, 32'hFFFF_FFFF, "mtlo_ones");
    run_op(2'b10, 1'b0, 32'd1, 32'd1, 0, 0, "madd_carry");
    n_tests++;
    if (HI !== 32'd1 || LO !== 32'd0) begin
      n_fail++; $display("FAIL madd_const: got %h_%h want 00000001_00000000", HI, LO);
    end
    run_op(2'b11, 1'b0, 32'd1, 32'd1, 0, 0, "msub_borrow");
    n_tests++;
    if (HI !== 32'd0 || LO !== 32'hFFFF_FFFF) begin
      n_fail++; $display("FAIL msub_const: got %h_%h want 00000000_ffffffff", HI, LO);
    end
  endtask

  task automatic test_respon();
    @(negedge clk);
    E_valid = 1; startE = 1; respon = 1; MDopE = 2'b00; rd1E = 32'd7; rd2E = 32'd9;
    @(negedge clk);
    idle_inputs();
    n_tests++;
    if (busy !== 1'b0 || HI !== m_hi || LO !== m_lo) begin
      n_fail++;
      $display("FAIL respon_suppress: got busy=%b %h_%h want 0 %h_%h", busy, HI, LO, m_hi, m_lo);
    end
    @(negedge clk);
    E_valid = 1; HIWriteE = 1; respon = 1; HIReadE = 0; rd1E = 32'hDEAD_BEEF;
    @(negedge clk);
    idle_inputs();
    n_tests++;
    if (LO !== m_lo) begin
      n_fail++; $display("FAIL respon_mt: got %h want %h", LO, m_lo);
    end
    run_op(2'b00, 1'b1, 32'h0001_2345, 32'hFFFF_0001, 1, 0, "respon_inflight");
    run_op(2'b01, 1'b0, 32'd1000, 32'd33, 2, 0, "evalid0_inflight");
    run_op(2'b00, 1'b0, 32'd11, 32'd13, 0, 1, "start_and_mt");
  endtask

  task automatic test_reset_mid();
    @(negedge clk);
    E_valid = 1; startE = 1; MDopE = 2'b01; MDsignE = 0; rd1E = 32'd500; rd2E = 32'd3;
    @(negedge clk);
    idle_inputs();
    repeat (4) @(negedge clk);
    reset = 1;
    @(negedge clk);
    reset = 0;
    m_hi = 32'd0; m_lo = 32'd0;
    n_tests++;
    if (busy !== 1'b0 || HI !== 32'd0 || LO !== 32'd0) begin
      n_fail++;
      $display("FAIL reset_mid_div: got busy=%b %h_%h want 0 0_0", busy, HI, LO);
    end
    repeat (DIV_LAT) @(negedge clk);
    n_tests++;
    if (HI !== 32'd0 || LO !== 32'd0) begin
      n_fail++; $display("FAIL reset_discard: got %h_%h want 0_0", HI, LO);
    end
    run_op(2'b00, 1'b0, 32'd2, 32'd3, 0, 0, "mult_after_reset");
  endtask

  task automatic test_random();
    logic [1:0]  op;
    logic        sg;
    logic [31:0] a, b;
    for (int i = 0; i < 40; i++) begin
      op = 2'($urandom_range(0, 3));
      sg = 1'($urandom_range(0, 1));
      a  = $urandom;
      case ($urandom_range(0, 7))
        0:       b = 32'd0;
        1:       b = 32'hFFFF_FFFF;
        2:       b = 32'($urandom_range(1, 9));
        default: b = $urandom;
      endcase
      if ($urandom_range(0, 7) == 0) a = 32'h8000_0000;
      if ($urandom_range(0, 5) == 0) do_mt(1'($urandom_range(0, 1)), $urandom, "rand_mt");
      run_op(op, sg, a, b, 0, 0, "rand_op");
    end
  endtask

  initial begin
    reset = 1;
    idle_inputs();
    @(negedge clk);
    test_reset();
    test_mult();
    test_div_stall();
    test_div_special();
    test_madd_msub();
    test_respon();
    test_reset_mid();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/mdu_sched.md
Name: mdu_sched

Overview:
- Multi-cycle multiply/divide scheduler and HI/LO owner for the E stage.
- Accepts MD requests from the E pipeline register and sequences a fixed-latency multiply or divide.
- Holds the HI/LO result registers and returns HI/LO reads.
- Raises a stall towards E_allowin logic whenever an MD-class instruction in E must wait for an operation in flight.

Parameters:
- MUL_LAT, 5: busy cycles for MULT/MADD/MSUB; legal range 1..31.
- DIV_LAT, 10: busy cycles for DIV; legal range 1..31.

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous active-high reset.
- respon  in  1  exception flush; suppresses any request presented this cycle.
- E_valid  in  1  E stage holds a valid instruction.
- startE  in  1  E instruction is MULT/DIV/MADD/MSUB.
- MDopE  in  2  operation: 00 MULT, 01 DIV, 10 MADD, 11 MSUB.
- MDsignE  in  1  1 = signed operands, 0 = unsigned.
- HIWriteE  in  1  E instruction is MTHI/MTLO.
- HLToRegE  in  1  E instruction is MFHI/MFLO.
- HIReadE  in  1  1 selects HI, 0 selects LO, for both MT and MF.
- rd1E  in  32  operand A / MT source.
- rd2E  in  32  operand B.
- busy  out  1  operation in flight.
- md_stall  out  1  E must hold.
- hl_rdata  out  32  MF read data.
- HI  out  32  HI register.
- LO  out  32  LO register.

Behaviour:
- Interface: one clock; reset is synchronous and active-high (clk, reset).
- Reset: state IDLE; cnt=0; busy=0; HI=0; LO=0; md_stall=0.
- go = E_valid & startE & ~respon & ~busy.
- mt = E_valid & HIWriteE & ~respon & ~busy.
- md_stall = E_valid & (startE | HIWriteE | HLToRegE) & busy. It is combinational and does not depend on respon.
- hl_rdata = HIReadE ? HI : LO, combinational. It is only meaningful when md_stall=0.
- FSM states: IDLE, MUL, DIV.
  - IDLE: on go, latch rd1E, rd2E, MDopE, MDsignE. Enter MUL with cnt=MUL_LAT-1, or DIV (op 01) with cnt=DIV_LAT-1.
  - MUL/DIV: cnt decrements each cycle. In the cycle with cnt==0, HI/LO are written at the clock edge and the next state is IDLE.
- Timing: go sampled in cycle T → busy=1 in cycles T+1..T+LAT → HI/LO hold new values and busy=0 in T+LAT+1.
- A second MD-class instruction in cycle T+1 stalls exactly LAT cycles.
- Arithmetic (A, B = latched operands; sign per MDsign):
  - MULT: {HI,LO} = A*B, 64-bit.
  - MADD: {HI,LO} = {HI,LO} + A*B.
  - MSUB: {HI,LO} = {HI,LO} − A*B.
  - MADD/MSUB use the HI/LO values current at completion, modulo 2^64.
  - DIV: LO = quotient truncated toward zero; HI = remainder with the sign of the dividend.
  - Signed 0x80000000 / 0xFFFFFFFF: LO = 0x80000000, HI = 0.
  - Divide by zero (either signedness): LO = 0xFFFFFFFF, HI = A.
- MT: on mt, HI (HIReadE=1) or LO (HIReadE=0) = rd1E at the clock edge. A MT never coincides with a completion, because it requires ~busy.
- respon:
  - Suppresses go and mt in the same cycle.
  - An operation already in flight is not cancelled; it completes and writes HI/LO.
- reset mid-operation: immediate return to IDLE; HI/LO cleared; the result is discarded.
- startE and HIWriteE both set: illegal decode; startE wins and the MT is ignored.
- E_valid=0: all request inputs are ignored; md_stall=0.

Decomposition:
- Shared package mdu_pkg: MDop encodings (MD_MULT, MD_DIV, MD_MADD, MD_MSUB) and state encodings (S_IDLE, S_MUL, S_DIV).
- One sub-module, mdu_arith: combinational 64-bit signed/unsigned product plus quotient/remainder, including the divide-by-zero and overflow rules above. The FSM, counter and HI/LO registers stay in mdu_sched.
- Replacing mdu_arith with an iterative datapath must preserve the exact LAT timing.

Test Plan:
- MULT signed: A=0xFFFFFFFE, B=3 → busy for 5 cycles, then HI=0xFFFFFFFF, LO=0xFFFFFFFA; busy falls at T+6.
- DIV unsigned 100/7 followed by MFLO in the next cycle → md_stall=1 for 10 cycles, then hl_rdata=14; MFHI gives 2.
- Signed DIV −7/2 → LO=0xFFFFFFFD, HI=0xFFFFFFFF. Divide by zero with A=5 → LO=0xFFFFFFFF, HI=5.
- MTHI 0 and MTLO 0xFFFFFFFF, then MADD unsigned 1*1 → HI=1, LO=0. Then MSUB 1*1 → HI=0, LO=0xFFFFFFFF.
- respon=1 together with startE → no busy and HI/LO unchanged. respon during a MUL in flight → the result still lands at T+6.
- reset asserted in the middle of a DIV → next cycle busy=0, HI=LO=0, and a new MULT 2*3 gives LO=6.
